// File: rtl/wb_write_arbiter.sv
// Purpose : owns the register-file write port and shares it between pipeline
//           writeback and debug register writes; pipeline writes always win.
// Latency : 1 cycle from the winning request to rf_*; debug worst case is
//           bounded by the starvation counter plus the forced stall.
// Backpressure: a debug request is held (level) until dbg_ack; after
//           STARVE_MAX denied cycles stall_pipe freezes the pipeline so the
//           debug write can land.
//
// Ports:
//   clk, reset                       system clock, synchronous active-high reset
//   pipe_regWrite/WriteReg/WriteData MEM/WB write request and WB-mux data
//   dbg_req/addr/data, dbg_ack       debug write request (level) and done pulse
//   stall_pipe                       to hazard unit: freeze pipe, bubble MEM/WB
//   rf_we/rf_waddr/rf_wdata          registered register-file write port
//   conflict_err                     sticky: pipeline wrote during forced stall
module wb_write_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_regWrite,
    input  logic [ADDR_W-1:0] pipe_writeReg,
    input  logic [DATA_W-1:0] pipe_writeData,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              dbg_ack,
    output logic              stall_pipe,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              conflict_err
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STALL = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;

    logic              dbg_ack_q, dbg_ack_d;
    logic              stall_q, stall_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              conflict_q, conflict_d;

    logic              pipe_hit;
    logic              dbg_grant;

    // Writes to register 0 are discarded by the register file, so they do
    // not occupy the port and never block a debug write.
    assign pipe_hit  = pipe_regWrite && (pipe_writeReg != '0);

    // In ACK the request still held high is the one already served; a new
    // grant needs dbg_req to go low first (ACK -> IDLE).
    assign dbg_grant = (state_q != ST_ACK) && dbg_req && !pipe_hit;

    assign cnt_inc   = cnt_q + CNT_W'(1);

    // ------------------------------------------------------------------
    // State register (also holds the registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dbg_ack_q  <= 1'b0;
            stall_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dbg_ack_q  <= dbg_ack_d;
            stall_q    <= stall_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            conflict_q <= conflict_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and starvation counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (!dbg_req) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (dbg_grant) begin
                    state_d = ST_ACK;
                    cnt_d   = '0;
                end else begin
                    // Denied only because the pipeline hit the port.
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == CNT_LIMIT) ? ST_STALL : ST_WAIT;
                end
            end
            ST_STALL: begin
                if (!dbg_req) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (dbg_grant) begin
                    state_d = ST_ACK;
                    cnt_d   = '0;
                end
                // A pipeline hit here breaks the hazard contract: stay in
                // STALL and keep waiting for a free cycle.
            end
            ST_ACK: begin
                cnt_d = '0;
                if (!dbg_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output next-values (all outputs are flop outputs)
    // ------------------------------------------------------------------
    always_comb begin
        dbg_ack_d  = dbg_grant;
        stall_d    = (state_d == ST_STALL);
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        conflict_d = conflict_q || ((state_q == ST_STALL) && pipe_hit);

        if (dbg_grant) begin
            // A debug write to register 0 is acknowledged but not enabled.
            rf_we_d    = (dbg_addr != '0);
            rf_waddr_d = dbg_addr;
            rf_wdata_d = dbg_data;
        end else if (pipe_hit) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = pipe_writeReg;
            rf_wdata_d = pipe_writeData;
        end
    end

    assign dbg_ack      = dbg_ack_q;
    assign stall_pipe   = stall_q;
    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign conflict_err = conflict_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              pipe_regWrite;
    logic [ADDR_W-1:0] pipe_writeReg;
    logic [DATA_W-1:0] pipe_writeData;
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic              dbg_ack;
    logic              stall_pipe;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              conflict_err;

    int errors = 0;
    int checks = 0;

    wb_write_arbiter #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .STARVE_MAX(8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pipe_regWrite (pipe_regWrite),
        .pipe_writeReg (pipe_writeReg),
        .pipe_writeData(pipe_writeData),
        .dbg_req       (dbg_req),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data),
        .dbg_ack       (dbg_ack),
        .stall_pipe    (stall_pipe),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .conflict_err  (conflict_err)
    );

    always #5 clk = ~clk;

    // Advance one active edge, then sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic we, input logic [4:0] waddr,
                             input logic [31:0] wdata, input logic ack,
                             input logic stall, input logic err);
        chk({tag, ".rf_we"},        32'(rf_we),        32'(we));
        chk({tag, ".rf_waddr"},     32'(rf_waddr),     32'(waddr));
        chk({tag, ".rf_wdata"},     rf_wdata,          wdata);
        chk({tag, ".dbg_ack"},      32'(dbg_ack),      32'(ack));
        chk({tag, ".stall_pipe"},   32'(stall_pipe),   32'(stall));
        chk({tag, ".conflict_err"}, 32'(conflict_err), 32'(err));
    endtask

    task automatic set_pipe(input logic we, input logic [4:0] reg_i, input logic [31:0] dat);
        pipe_regWrite  = we;
        pipe_writeReg  = reg_i;
        pipe_writeData = dat;
    endtask

    task automatic set_dbg(input logic req, input logic [4:0] addr, input logic [31:0] dat);
        dbg_req  = req;
        dbg_addr = addr;
        dbg_data = dat;
    endtask

    initial begin
        // ---- Reset with all inputs active ----
        reset = 1'b1;
        set_pipe(1'b1, 5'd7, 32'hFFFF_FFFF);
        set_dbg(1'b1, 5'd3, 32'hAAAA_AAAA);
        tick();
        check_all("reset_active", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        set_pipe(1'b0, 5'd0, 32'h0);
        set_dbg(1'b0, 5'd0, 32'h0);
        tick();
        check_all("reset_idle", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);

        // ---- Pipeline write, then a write to $0 ----
        set_pipe(1'b1, 5'd5, 32'hDEAD_BEEF);
        tick();
        check_all("pipe_w5", 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        set_pipe(1'b1, 5'd0, 32'h1111_1111);
        tick();
        check_all("pipe_w0", 1'b0, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        set_pipe(1'b0, 5'd0, 32'h0);

        // ---- Debug write on idle pipeline, request held afterwards ----
        set_dbg(1'b1, 5'd3, 32'h1234_5678);
        tick();
        check_all("dbg_w3", 1'b1, 5'd3, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        tick();
        check_all("dbg_held1", 1'b0, 5'd3, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("dbg_held2", 1'b0, 5'd3, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        set_dbg(1'b0, 5'd0, 32'h0);
        tick();
        check_all("dbg_drop", 1'b0, 5'd3, 32'h1234_5678, 1'b0, 1'b0, 1'b0);

        // ---- Debug write to $0: acked, write enable stays low ----
        set_dbg(1'b1, 5'd0, 32'h0000_0055);
        tick();
        check_all("dbg_w0", 1'b0, 5'd0, 32'h0000_0055, 1'b1, 1'b0, 1'b0);
        set_dbg(1'b0, 5'd0, 32'h0);
        tick();

        // ---- Starvation: 8 denied cycles force a stall ----
        set_dbg(1'b1, 5'd9, 32'hA5A5_A5A5);
        for (int k = 1; k <= 8; k++) begin
            set_pipe(1'b1, 5'd4, 32'h1000_0000 + 32'(k));
            tick();
            check_all($sformatf("starve%0d", k), 1'b1, 5'd4, 32'h1000_0000 + 32'(k),
                      1'b0, (k == 8), 1'b0);
        end
        set_pipe(1'b0, 5'd0, 32'h0);
        tick();
        check_all("starve_grant", 1'b1, 5'd9, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b0);
        tick();
        check_all("starve_ackhold", 1'b0, 5'd9, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0);
        set_dbg(1'b0, 5'd0, 32'h0);
        tick();

        // ---- Contract violation: pipeline writes while stalled ----
        set_dbg(1'b1, 5'd10, 32'hCAFE_F00D);
        for (int k = 1; k <= 8; k++) begin
            set_pipe(1'b1, 5'd6, 32'h2000_0000 + 32'(k));
            tick();
            chk($sformatf("viol_stall%0d", k), 32'(stall_pipe), 32'(k == 8));
        end
        set_pipe(1'b1, 5'd7, 32'h7777_7777);
        tick();
        check_all("viol_pipe", 1'b1, 5'd7, 32'h7777_7777, 1'b0, 1'b1, 1'b1);
        set_pipe(1'b0, 5'd0, 32'h0);
        tick();
        check_all("viol_grant", 1'b1, 5'd10, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b1);
        set_dbg(1'b0, 5'd0, 32'h0);
        tick();
        check_all("viol_idle1", 1'b0, 5'd10, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        check_all("viol_idle3", 1'b0, 5'd10, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        check_all("viol_reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // ---- Abandon in WAIT clears the counter ----
        set_dbg(1'b1, 5'd12, 32'hBBBB_0000);
        for (int k = 1; k <= 3; k++) begin
            set_pipe(1'b1, 5'd2, 32'h0000_0020 + 32'(k));
            tick();
            chk($sformatf("wait_stall%0d", k), 32'(stall_pipe), 32'h0);
        end
        set_dbg(1'b0, 5'd12, 32'hBBBB_0000);
        set_pipe(1'b1, 5'd2, 32'h0000_0030);
        tick();
        check_all("abandon", 1'b1, 5'd2, 32'h0000_0030, 1'b0, 1'b0, 1'b0);
        // A full fresh count of 8 is needed again before the stall.
        set_dbg(1'b1, 5'd12, 32'hBBBB_0000);
        for (int k = 1; k <= 8; k++) begin
            set_pipe(1'b1, 5'd2, 32'h0000_0040 + 32'(k));
            tick();
            chk($sformatf("recount_stall%0d", k), 32'(stall_pipe), 32'(k == 8));
            chk($sformatf("recount_ack%0d", k), 32'(dbg_ack), 32'h0);
        end

        // ---- Reset while in STALL: no write, stall drops ----
        reset = 1'b1;
        set_pipe(1'b0, 5'd0, 32'h0);
        tick();
        check_all("stall_reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        set_dbg(1'b0, 5'd0, 32'h0);
        tick();
        check_all("post_reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
